// File: rtl/regfile_rename_pkg.sv
// -----------------------------------------------------------------------------
// regfile_rename_pkg
//   Shared configuration for the rename-aware architectural register file.
//   Holds the default geometry (register count, data width, ROB tag width,
//   read port count), the named widths used across the block, and a helper
//   for sizing the busy counter.
// -----------------------------------------------------------------------------
package regfile_rename_pkg;

  // Default geometry of the register file
  localparam int NREG_DEF = 32;
  localparam int DW_DEF   = 32;
  localparam int TW_DEF   = 4;
  localparam int NRD_DEF  = 2;

  // Named widths shared with the rest of the core
  localparam int RegAddrLen = $clog2(NREG_DEF);
  localparam int RegLen     = DW_DEF;
  localparam int RobTagLen  = TW_DEF;

  localparam logic [RegLen-1:0]     ZERO_WORD   = {RegLen{1'b0}};
  localparam logic [RegAddrLen-1:0] RegAddrZero = {RegAddrLen{1'b0}};

  // Width needed to count 0..n inclusive
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/regfile_rename_if.sv
// -----------------------------------------------------------------------------
// regfile_rename_if
//   Bundle between decode/issue + ROB (master) and the register file (slave).
//   master drives: rdy, flush, ren_en/ren_addr/ren_tag,
//                  cmt_en/cmt_addr/cmt_tag/cmt_data, rd_addr
//   slave drives : rd_data, rd_busy, rd_tag, busy_count
//   Read port i occupies [i*AW +: AW] of rd_addr, [i*DW +: DW] of rd_data and
//   [i*TW +: TW] of rd_tag.
// -----------------------------------------------------------------------------
interface regfile_rename_if
  import regfile_rename_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int TW   = TW_DEF,
  parameter int NRD  = NRD_DEF
);
  localparam int AW = $clog2(NREG);
  localparam int CW = count_width(NREG);

  logic              rdy;
  logic              flush;
  logic              ren_en;
  logic [AW-1:0]     ren_addr;
  logic [TW-1:0]     ren_tag;
  logic              cmt_en;
  logic [AW-1:0]     cmt_addr;
  logic [TW-1:0]     cmt_tag;
  logic [DW-1:0]     cmt_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NRD*TW-1:0] rd_tag;
  logic [CW-1:0]     busy_count;

  modport master (
    output rdy, flush, ren_en, ren_addr, ren_tag,
           cmt_en, cmt_addr, cmt_tag, cmt_data, rd_addr,
    input  rd_data, rd_busy, rd_tag, busy_count
  );

  modport slave (
    input  rdy, flush, ren_en, ren_addr, ren_tag,
           cmt_en, cmt_addr, cmt_tag, cmt_data, rd_addr,
    output rd_data, rd_busy, rd_tag, busy_count
  );

endinterface

// File: rtl/regfile_rename_status_table.sv
// -----------------------------------------------------------------------------
// regfile_status_table
//   Rename status of every architectural register: busy bit, producing ROB
//   tag, and the number of registers currently renamed.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     rdy_i                   global ready, state holds when low
//     flush_i                 drop every rename
//     ren_en_i/addr/tag       rename a destination to a ROB tag
//     cmt_en_i/addr/tag       ROB commit, releases a matching rename
//     busy_o, tag_o           current status of each register
//     busy_count_o            number of busy registers
//   Register 0 is never renamed, so its busy bit and tag stay zero.
// -----------------------------------------------------------------------------
module regfile_status_table
  import regfile_rename_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int TW   = TW_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = count_width(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy_i,
  input  logic          flush_i,
  input  logic          ren_en_i,
  input  logic [AW-1:0] ren_addr_i,
  input  logic [TW-1:0] ren_tag_i,
  input  logic          cmt_en_i,
  input  logic [AW-1:0] cmt_addr_i,
  input  logic [TW-1:0] cmt_tag_i,
  output logic [NREG-1:0] busy_o,
  output logic [TW-1:0] tag_o [NREG],
  output logic [CW-1:0] busy_count_o
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX   = CW'(NREG - 1);

  logic [NREG-1:0] busy_q, busy_d;
  logic [TW-1:0]   tag_q [NREG];
  logic [TW-1:0]   tag_d [NREG];
  logic [CW-1:0]   cnt_q, cnt_d;

  logic flush_s;
  logic cmt_hit_s;
  logic ren_hit_s;
  logic inc_s;
  logic dec_s;

  // A commit only releases the rename it produced: an older producer whose
  // tag was superseded by a newer rename leaves the register busy.
  assign flush_s   = rdy_i & flush_i;
  assign cmt_hit_s = rdy_i & cmt_en_i & (cmt_addr_i != ADDR_ZERO)
                   & busy_q[cmt_addr_i] & (tag_q[cmt_addr_i] == cmt_tag_i);
  assign ren_hit_s = rdy_i & ren_en_i & (ren_addr_i != ADDR_ZERO) & ~flush_i;

  // Counter moves only when a bit really changes; a rename on top of a
  // clearing commit to the same register leaves the count untouched.
  assign inc_s = ren_hit_s & ~busy_q[ren_addr_i];
  assign dec_s = cmt_hit_s & ~(ren_hit_s & (ren_addr_i == cmt_addr_i));

  // Next busy bits and tags: rename beats commit-clear, flush beats both
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int i = 0; i < NREG; i++) begin
      busy_d[i] = ~flush_s
                & ((ren_hit_s & (ren_addr_i == AW'(i)))
                 | (busy_q[i] & ~(cmt_hit_s & (cmt_addr_i == AW'(i)))));
      tag_d[i]  = (ren_hit_s && (ren_addr_i == AW'(i))) ? ren_tag_i : tag_q[i];
    end
  end

  // Next busy count, saturating at the number of renameable registers
  always_comb begin
    cnt_d = cnt_q;
    case ({flush_s, inc_s, dec_s})
      3'b010:  cnt_d = (cnt_q < CNT_MAX) ? (cnt_q + CNT_ONE) : cnt_q;
      3'b001:  cnt_d = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : cnt_q;
      3'b100,
      3'b101,
      3'b110,
      3'b111:  cnt_d = CNT_ZERO;
      default: cnt_d = cnt_q;
    endcase
  end

  // Status state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {NREG{1'b0}};
      cnt_q  <= CNT_ZERO;
      for (int i = 0; i < NREG; i++) begin
        tag_q[i] <= {TW{1'b0}};
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
    end
  end

  assign busy_o       = busy_q;
  assign tag_o        = tag_q;
  assign busy_count_o = cnt_q;

endmodule

// File: rtl/regfile_rename.sv
// -----------------------------------------------------------------------------
// regfile_rename
//   Architectural register file with per-register rename status for the
//   out-of-order core. Issue reads operands (value or producing ROB tag) and
//   renames destinations; ROB commit writes values back and releases renames;
//   flush drops every rename.
//   Ports:
//     clk    clock, all state updates on posedge
//     rst_n  asynchronous active-low reset
//     bus    regfile_rename_if.slave (rename/commit/flush inputs, read ports,
//            busy_count)
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : a read hitting an active commit returns cmt_data and the
//                 post-commit busy state in the same cycle
//     undefined : reads show pre-edge state only
//   Same-cycle renames are never forwarded to read ports.
// -----------------------------------------------------------------------------
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int TW   = TW_DEF,
  parameter int NRD  = NRD_DEF
) (
  input logic            clk,
  input logic            rst_n,
  regfile_rename_if.slave bus
);

  localparam int AW = $clog2(NREG);
  localparam int CW = count_width(NREG);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] busy_s;
  logic [TW-1:0]   tag_s [NREG];
  logic [CW-1:0]   busy_count_s;
  logic            cmt_act_s;

  logic [NRD*DW-1:0] rd_data_s;
  logic [NRD-1:0]    rd_busy_s;
  logic [NRD*TW-1:0] rd_tag_s;
  logic [AW-1:0]     ra_s;
  logic [DW-1:0]     val_s;
  logic              bsy_s;
  logic [TW-1:0]     tg_s;

  // Register 0 is excluded here, so its entry keeps the reset value of zero.
  assign cmt_act_s = bus.rdy & bus.cmt_en & (bus.cmt_addr != ADDR_ZERO);

  regfile_status_table #(
    .NREG (NREG),
    .TW   (TW),
    .AW   (AW),
    .CW   (CW)
  ) u_status (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy_i        (bus.rdy),
    .flush_i      (bus.flush),
    .ren_en_i     (bus.ren_en),
    .ren_addr_i   (bus.ren_addr),
    .ren_tag_i    (bus.ren_tag),
    .cmt_en_i     (bus.cmt_en),
    .cmt_addr_i   (bus.cmt_addr),
    .cmt_tag_i    (bus.cmt_tag),
    .busy_o       (busy_s),
    .tag_o        (tag_s),
    .busy_count_o (busy_count_s)
  );

  // Data array: commit write-back, independent of flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= ZERO_WORD[DW-1:0];
      end
    end else if (cmt_act_s) begin
      regs_q[bus.cmt_addr] <= bus.cmt_data;
    end
  end

  // Read ports: value, busy and tag of the addressed register
  always_comb begin
    rd_data_s = {(NRD*DW){1'b0}};
    rd_busy_s = {NRD{1'b0}};
    rd_tag_s  = {(NRD*TW){1'b0}};
    ra_s      = ADDR_ZERO;
    val_s     = {DW{1'b0}};
    bsy_s     = 1'b0;
    tg_s      = {TW{1'b0}};
    for (int p = 0; p < NRD; p++) begin
      ra_s  = bus.rd_addr[p*AW +: AW];
      val_s = regs_q[ra_s];
      bsy_s = busy_s[ra_s];
      tg_s  = tag_s[ra_s];
`ifdef REGFILE_BYPASS_EN
      // Forward the committing value; busy drops only if this commit is the
      // producer the register is still waiting on.
      if (cmt_act_s && (bus.cmt_addr == ra_s)) begin
        val_s = bus.cmt_data;
        bsy_s = bsy_s & (tg_s != bus.cmt_tag);
      end else begin
        val_s = regs_q[ra_s];
        bsy_s = busy_s[ra_s];
      end
`endif
      rd_data_s[p*DW +: DW] = val_s;
      rd_busy_s[p]          = bsy_s;
      rd_tag_s[p*TW +: TW]  = tg_s;
    end
  end

  assign bus.rd_data    = rd_data_s;
  assign bus.rd_busy    = rd_busy_s;
  assign bus.rd_tag     = rd_tag_s;
  assign bus.busy_count = busy_count_s;

endmodule

// File: tb/tb_regfile_rename.sv
// -----------------------------------------------------------------------------
// tb_regfile_rename
//   Scoreboard bench for regfile_rename. The driver computes the expected read
//   response from a behavioural model (plain arrays updated by the rename /
//   commit / flush rules) and queues it; a negedge monitor pops and compares.
//   Directed scenarios additionally check hand-derived constants.
// -----------------------------------------------------------------------------
module tb_regfile_rename;
  import regfile_rename_pkg::*;

  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int TW   = 4;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_rename_if #(.NREG(NREG), .DW(DW), .TW(TW), .NRD(NRD)) bus ();

  regfile_rename #(.NREG(NREG), .DW(DW), .TW(TW), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model
  logic [DW-1:0] m_reg  [NREG];
  logic          m_busy [NREG];
  logic [TW-1:0] m_tag  [NREG];

  typedef struct {
    logic [NRD*DW-1:0] d;
    logic [NRD-1:0]    b;
    logic [NRD*TW-1:0] t;
    logic [NRD-1:0]    tchk;
    logic [CW-1:0]     cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  // Apply one clock edge to the model, rules in priority order
  task automatic model_edge();
    int ca;
    int ra;
    ca = int'(bus.cmt_addr);
    ra = int'(bus.ren_addr);
    if (rst_n && bus.rdy) begin
      if (bus.cmt_en && ca != 0) begin
        m_reg[ca] = bus.cmt_data;
        if (m_busy[ca] && m_tag[ca] == bus.cmt_tag) m_busy[ca] = 1'b0;
      end
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else if (bus.ren_en && ra != 0) begin
        m_busy[ra] = 1'b1;
        m_tag[ra]  = bus.ren_tag;
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int a;
    int c;
    logic [DW-1:0] d;
    logic b;
    logic [TW-1:0] t;
    c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    e.cnt = CW'(c);
    for (int p = 0; p < NRD; p++) begin
      a = int'(bus.rd_addr[p*AW +: AW]);
      d = m_reg[a];
      b = m_busy[a];
      t = m_tag[a];
      if (BYP && bus.rdy && bus.cmt_en && bus.cmt_addr != '0 && int'(bus.cmt_addr) == a) begin
        d = bus.cmt_data;
        if (b && t == bus.cmt_tag) b = 1'b0;
      end
      e.d[p*DW +: DW] = d;
      e.b[p]          = b;
      e.t[p*TW +: TW] = t;
      e.tchk[p]       = b || (a == 0);
    end
    return e;
  endfunction

  // Monitor: compare DUT read ports with the queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("mon_data%0d", p), 64'(bus.rd_data[p*DW +: DW]), 64'(e.d[p*DW +: DW]));
        chk($sformatf("mon_busy%0d", p), 64'(bus.rd_busy[p]), 64'(e.b[p]));
        if (e.tchk[p]) chk($sformatf("mon_tag%0d", p), 64'(bus.rd_tag[p*TW +: TW]), 64'(e.t[p*TW +: TW]));
      end
      chk("mon_count", 64'(bus.busy_count), 64'(e.cnt));
    end
  end

  task automatic idle();
    bus.rdy      = 1'b1;
    bus.flush    = 1'b0;
    bus.ren_en   = 1'b0;
    bus.ren_addr = '0;
    bus.ren_tag  = '0;
    bus.cmt_en   = 1'b0;
    bus.cmt_addr = '0;
    bus.cmt_tag  = '0;
    bus.cmt_data = '0;
    bus.rd_addr  = '0;
  endtask

  // Queue the expectation for the current inputs, then take one edge
  task automatic cycle();
    exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ren(input int a, input int t);
    idle();
    bus.ren_en = 1'b1; bus.ren_addr = AW'(a); bus.ren_tag = TW'(t);
  endtask

  task automatic cmt(input int a, input int t, input logic [DW-1:0] d);
    bus.cmt_en = 1'b1; bus.cmt_addr = AW'(a); bus.cmt_tag = TW'(t); bus.cmt_data = d;
  endtask

  // Direct constant check of one read port (and optionally busy_count)
  task automatic peek(input string nm, input int p, input int a, input logic [DW-1:0] wd,
                      input logic wb, input logic [TW-1:0] wt, input int wc);
    bus.rd_addr[p*AW +: AW] = AW'(a);
    #1;
    chk({nm, "_data"}, 64'(bus.rd_data[p*DW +: DW]), 64'(wd));
    chk({nm, "_busy"}, 64'(bus.rd_busy[p]), 64'(wb));
    if (wb) chk({nm, "_tag"}, 64'(bus.rd_tag[p*TW +: TW]), 64'(wt));
    if (wc >= 0) chk({nm, "_cnt"}, 64'(bus.busy_count), 64'(wc));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(posedge clk); #1;
    cycle();
    rst_n = 1'b1;
    cycle();

    // Rename then matching commit
    ren(5, 3); cycle();
    idle(); peek("ren5", 0, 5, 32'h0, 1'b1, 4'd3, 1);
    cmt(5, 3, 32'hDEADBEEF); cycle();
    idle(); peek("cmt5", 0, 5, 32'hDEADBEEF, 1'b0, 4'd0, 0);

    // Older producer commits, newer rename kept
    ren(5, 3); cycle();
    ren(5, 7); cycle();
    idle(); cmt(5, 3, 32'h0000_1234); cycle();
    idle(); peek("old_cmt", 0, 5, 32'h0000_1234, 1'b1, 4'd7, 1);

    // Commit and rename same register same cycle
    ren(6, 2); cycle();
    ren(6, 4); cmt(6, 2, 32'hA5A5_A5A5); cycle();
    idle(); peek("cmt_ren", 1, 6, 32'hA5A5_A5A5, 1'b1, 4'd4, 2);

    // Flush drops renames, including a same-cycle rename
    for (int r = 1; r <= 4; r++) begin ren(r, r); cycle(); end
    ren(9, 1); bus.flush = 1'b1; cycle();
    idle(); peek("flush", 0, 9, 32'h0, 1'b0, 4'd0, 0);

    // Commit x7 while reading it
    idle(); cmt(7, 0, 32'h0000_0055);
    peek("byp", 1, 7, BYP ? 32'h0000_0055 : 32'h0, 1'b0, 4'd0, -1);
    cycle();
    idle(); peek("post_cmt7", 1, 7, 32'h0000_0055, 1'b0, 4'd0, -1);

    // Register 0 is never written or renamed
    ren(0, 5); cmt(0, 5, 32'hFFFF_FFFF); cycle();
    idle(); peek("x0", 0, 0, 32'h0, 1'b0, 4'd0, 0);

    // rdy=0 freezes all state
    ren(10, 6); cycle();
    for (int k = 0; k < 3; k++) begin
      ren(8, 1); cmt(8, 0, 32'h0000_0099); bus.flush = 1'b1; bus.rdy = 1'b0;
      cycle();
    end
    idle(); peek("hold8", 0, 8, 32'h0, 1'b0, 4'd0, 1);
    peek("hold10", 1, 10, 32'h0, 1'b1, 4'd6, 1);

    // Randomized traffic on a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      int ca;
      bus.rdy      = ($urandom_range(0, 9) != 0);
      bus.flush    = ($urandom_range(0, 24) == 0);
      bus.ren_en   = 1'($urandom_range(0, 1));
      bus.ren_addr = AW'($urandom_range(0, 9));
      bus.ren_tag  = TW'($urandom);
      bus.cmt_en   = 1'($urandom_range(0, 1));
      ca           = $urandom_range(0, 9);
      bus.cmt_addr = AW'(ca);
      bus.cmt_tag  = ($urandom_range(0, 3) != 0) ? m_tag[ca] : TW'($urandom);
      bus.cmt_data = $urandom;
      for (int p = 0; p < NRD; p++) bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, 9));
      cycle();
    end

    // Asynchronous reset with busy registers
    ren(3, 1); cycle();
    idle(); cmt(4, 0, 32'h1357_9BDF); cycle();
    idle();
    rst_n = 1'b0;
    peek("async_rst3", 0, 3, 32'h0, 1'b0, 4'd0, 0);
    peek("async_rst4", 1, 4, 32'h0, 1'b0, 4'd0, 0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();

    @(negedge clk); #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
